keycode_bank: RTL and testbench

Parametrised Avalon-MM keycode register bank with a key-press event FIFO. It holds up to six simultaneous USB HID keycodes written by the Nios II software. Each slot is exported to the game logic as a flat output bus. Every write that installs a new non-zero keycode into a slot also pushes a `{slot, keycode}` event into a show-ahead FIFO, which the fabric drains with a valid/ready handshake. Status and control registers provide FIFO occupancy, a sticky overflow flag and a flush.

---
 rtl/keycode_bank.sv | 167 ++++++++++++++++
 tb/tb_keycode_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/keycode_bank.sv
// Avalon-MM keycode register bank with a show-ahead key-press event FIFO.
// Optional feature: define KEYCODE_BANK_IRQ_EN to add a registered irq output.
module keycode_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_KEYS   = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [2:0]                     address,
    input  logic                           chipselect,
    input  logic                           write_n,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    output logic [NUM_KEYS*DATA_WIDTH-1:0] out_keys,
    output logic                           any_key,
    output logic                           evt_valid,
    output logic [DATA_WIDTH+2:0]          evt_data,
    input  logic                           evt_ready
`ifdef KEYCODE_BANK_IRQ_EN
    ,
    output logic                           irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 3;
    localparam logic [2:0]    NK      = 3'(NUM_KEYS);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] slot_q [NUM_KEYS];
    logic [DATA_WIDTH-1:0] slot_d [NUM_KEYS];
    logic [EW-1:0]         mem_q  [FIFO_DEPTH];
    logic [EW-1:0]         mem_d  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_mask_s;

    logic                  wr_en_s, slot_wr_s, ctrl_wr_s, flush_s, ovf_clr_s;
    logic                  pop_s, full_s, push_req_s, do_push_s, drop_s;
    logic [DATA_WIDTH-1:0] new_key_s, cur_key_s;
    logic                  unused_s;

    assign unused_s = ^writedata;

`ifdef KEYCODE_BANK_IRQ_EN
    logic irq_mask_q, irq_mask_d, irq_q, irq_d;
    assign irq_mask_s = irq_mask_q;
    assign irq        = irq_q;
`else
    assign irq_mask_s = 1'b0;
`endif

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;

    // Bus decode and push/pop/drop arbitration.
    always_comb begin
        wr_en_s   = chipselect && !write_n;
        slot_wr_s = wr_en_s && (address < NK);
        ctrl_wr_s = wr_en_s && (address == 3'd7);
        flush_s   = ctrl_wr_s && writedata[1];
        ovf_clr_s = ctrl_wr_s && writedata[0];
        new_key_s = writedata[DATA_WIDTH-1:0];
        cur_key_s = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cur_key_s = (address == 3'(k)) ? slot_q[k] : cur_key_s;
        end
        pop_s      = evt_valid && evt_ready;
        full_s     = (count_q == DEPTH_C);
        // Only a fresh non-zero keycode is a press; releases and repeats are silent.
        push_req_s = slot_wr_s && (new_key_s != '0) && (new_key_s != cur_key_s);
        do_push_s  = push_req_s && (!full_s || pop_s) && !flush_s;
        drop_s     = push_req_s && full_s && !pop_s && !flush_s;
    end

    // Next-state for slots, FIFO storage, pointers and flags.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            slot_d[k] = (slot_wr_s && (address == 3'(k))) ? new_key_s : slot_q[k];
        end
        mem_d = mem_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = {address, new_key_s};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(pop_s);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
`ifdef KEYCODE_BANK_IRQ_EN
        irq_mask_d = ctrl_wr_s ? writedata[2] : irq_mask_q;
        irq_d      = irq_mask_q & (evt_valid | ovf_q);
`endif
    end

    // Flat slot export and key-held summary.
    always_comb begin
        out_keys = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            out_keys[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
        end
        any_key = |out_keys;
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = 32'd0;
        if (address < NK) begin
            readdata = 32'(cur_key_s);
        end else if (address == 3'd6) begin
            readdata = {21'd0, full_s, !evt_valid, ovf_q, 8'(count_q)};
        end else if (address == 3'd7) begin
            readdata = {29'd0, irq_mask_s, 2'd0};
        end else begin
            readdata = 32'd0;
        end
    end

    // State registers; reset also wipes FIFO contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) slot_q[k] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef KEYCODE_BANK_IRQ_EN
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            slot_q   <= slot_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
`ifdef KEYCODE_BANK_IRQ_EN
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_keycode_bank.sv
// Scoreboard bench for keycode_bank: expected events queued at stimulus, checked by a monitor on pop.
module tb_keycode_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [47:0] out_keys;
    logic        any_key;
    logic        evt_valid;
    logic [10:0] evt_data;
    logic        evt_ready;
`ifdef KEYCODE_BANK_IRQ_EN
    logic        irq;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    bit          mon_en = 1'b0;

    keycode_bank #(.DATA_WIDTH(8), .NUM_KEYS(6), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_keys(out_keys), .any_key(any_key), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_ready(evt_ready)
`ifdef KEYCODE_BANK_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (mon_en && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL evt_unexpected: got %0h, expected no event", evt_data);
            end else begin
                chk("evt_data", 64'(evt_data), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic ev, input logic rdy);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        evt_ready  = rdy;
        if (ev) exp_q.push_back({a, d[7:0]});
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        evt_ready  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chk(name, 64'(readdata), 64'(e));
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        evt_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        chk("rst_out_keys", 64'(out_keys), 64'd0);
        chk("rst_any_key", 64'(any_key), 64'd0);
        chk("rst_evt_valid", 64'(evt_valid), 64'd0);
        chk("rst_evt_data", 64'(evt_data), 64'd0);
`ifdef KEYCODE_BANK_IRQ_EN
        chk("rst_irq", 64'(irq), 64'd0);
`endif
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), (a == 6) ? 32'h200 : 32'h0, "rst_read");
        end

        // Two presses on different slots, popped in order.
        wr(3'd0, 32'h04, 1'b1, 1'b0);
        wr(3'd2, 32'h16, 1'b1, 1'b0);
        chk("out_keys_two", 64'(out_keys), 64'h0000_0016_0004);
        chk("any_key_two", 64'(any_key), 64'd1);
        rd(3'd6, 32'h002, "status_cnt2");
        rd(3'd2, 32'h016, "slot2_read");
        pop_one();
        rd(3'd6, 32'h001, "status_cnt1");
        pop_one();
        rd(3'd6, 32'h200, "status_cnt0");

        // Repeat and release generate no events.
        wr(3'd2, 32'h00, 1'b0, 1'b0);
        wr(3'd0, 32'h00, 1'b0, 1'b0);
        wr(3'd0, 32'h04, 1'b1, 1'b0);
        wr(3'd0, 32'h04, 1'b0, 1'b0);
        wr(3'd0, 32'h00, 1'b0, 1'b0);
        rd(3'd6, 32'h001, "status_repeat");
        chk("any_key_release", 64'(any_key), 64'd0);
        pop_one();
        rd(3'd6, 32'h200, "status_drained");

        // Overfill: the ninth event is dropped, slot still updates.
        for (int i = 0; i < 9; i++) begin
            wr(3'd0, 32'h20 + 32'(i), (i < 8), 1'b0);
        end
        rd(3'd6, 32'h508, "status_overflow");
        rd(3'd0, 32'h028, "slot0_after_drop");
        wr(3'd7, 32'h1, 1'b0, 1'b0);
        rd(3'd6, 32'h408, "status_ovf_clr");

        // Push and pop together while full.
        wr(3'd1, 32'h55, 1'b1, 1'b1);
        rd(3'd6, 32'h408, "status_full_pushpop");
        repeat (8) pop_one();
        rd(3'd6, 32'h200, "status_full_drained");

        // Flush discards pending events.
        wr(3'd3, 32'h33, 1'b1, 1'b0);
        rd(3'd6, 32'h001, "status_pre_flush");
        wr(3'd7, 32'h2, 1'b0, 1'b0);
        exp_q.delete();
        rd(3'd6, 32'h200, "status_flush");
        chk("evt_valid_flush", 64'(evt_valid), 64'd0);

        // Push with ready high while empty: no pop, event appears next cycle.
        wr(3'd4, 32'h44, 1'b1, 1'b1);
        chk("evt_valid_empty_push", 64'(evt_valid), 64'd1);
        pop_one();
        chk("evt_valid_after_pop", 64'(evt_valid), 64'd0);

        // irq mask storage and irq lag behind evt_valid.
        wr(3'd7, 32'h4, 1'b0, 1'b0);
`ifdef KEYCODE_BANK_IRQ_EN
        rd(3'd7, 32'h4, "control_mask");
        chk("irq_idle", 64'(irq), 64'd0);
        wr(3'd5, 32'h66, 1'b1, 1'b0);
        chk("irq_same_cycle", 64'(irq), 64'd0);
        @(posedge clk); #1;
        chk("irq_next_cycle", 64'(irq), 64'd1);
        pop_one();
`else
        rd(3'd7, 32'h0, "control_no_mask");
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
